// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU      = 2'd1,
        ST_MEMW     = 2'd2,
        ST_MDU_MEMW = 2'd3
    } pctrl_state_e;

    localparam int unsigned MDU_CYCLES_DEF  = 32;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    // A register dependency only exists for a real (non-$zero) destination that the reader uses.
    function automatic logic reg_match(input logic use_r, input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_r && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pctrl_mdu_timer.sv
// Down-counter for MDU hold cycles: load, decrement, saturate at zero.
module pctrl_mdu_timer #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOAD_VAL = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WIDTH'(LOAD_VAL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU hold, memory waits, branch kill.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_CYCLES  = MDU_CYCLES_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_Rs,
    input  logic [4:0]  id_Rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_branch_taken,
    input  logic        ex_mdu_start,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        flush_mem_wb,
    output logic        mdu_done,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt
);

    localparam int unsigned CNT_W  = $clog2(MDU_CYCLES);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    pctrl_state_e      state_q, state_d;
    logic              kill_pend_q;
    logic [WAIT_W-1:0] wait_cnt_q;

    logic mem_hold, load_use, ex_hold, mdu_busy, mdu_zero, mdu_load;
    logic front_stall, kill_set;

    pctrl_mdu_timer #(
        .WIDTH    (CNT_W),
        .LOAD_VAL (MDU_CYCLES - 1)
    ) u_mdu_timer (
        .clk  (clk),
        .rst  (rst),
        .load (mdu_load),
        .dec  (mdu_busy),
        .zero (mdu_zero)
    );

    always_comb begin
        mem_hold    = mem_req & ~mem_ack;
        load_use    = ex_MemRead & (reg_match(id_use_rs, id_Rs, ex_wreg) |
                                    reg_match(id_use_rt, id_Rt, ex_wreg));
        mdu_busy    = (state_q == ST_MDU) || (state_q == ST_MDU_MEMW);
        mdu_load    = (state_q == ST_RUN) & ex_mdu_start & ~mem_hold;
        ex_hold     = mdu_load | (mdu_busy & ~mdu_zero) | (state_q == ST_MDU_MEMW);
        front_stall = mem_hold | ex_hold | load_use;
        kill_set    = ex_branch_taken & load_use & ~mem_hold & ~ex_hold;
    end

    // All control outputs are forced low while reset is held.
    always_comb begin
        stall_pc     = ~rst & front_stall;
        stall_if_id  = ~rst & front_stall;
        stall_id_ex  = ~rst & (mem_hold | ex_hold);
        stall_ex_mem = ~rst & mem_hold;
        flush_mem_wb = ~rst & mem_hold;
        flush_ex_mem = ~rst & ex_hold & ~mem_hold;
        flush_id_ex  = ~rst & load_use & ~mem_hold & ~ex_hold;
        flush_if_id  = ~rst & (ex_branch_taken | kill_pend_q) & ~front_stall;
        mdu_done     = ~rst & (state_q == ST_MDU) & mdu_zero & ~mem_hold;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_hold)          state_d = ST_MEMW;
                else if (ex_mdu_start) state_d = ST_MDU;
            end
            ST_MDU: begin
                if (mem_hold)      state_d = ST_MDU_MEMW;
                else if (mdu_zero) state_d = ST_RUN;
            end
            ST_MDU_MEMW: if (!mem_hold) state_d = ST_MDU;
            ST_MEMW:     if (!mem_hold) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            kill_pend_q    <= 1'b0;
            wait_cnt_q     <= '0;
            mem_timeout    <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state_q <= state_d;

            // Branch left EX while IF/ID was held: its kill is owed to the next free cycle.
            if (flush_if_id)   kill_pend_q <= 1'b0;
            else if (kill_set) kill_pend_q <= 1'b1;

            if (mem_hold) begin
                if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) wait_cnt_q <= wait_cnt_q + 1'b1;
                if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end

            if (stall_pc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MDU_C  = 4;
    localparam int unsigned MEM_TO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_Rs, id_Rt, ex_wreg;
    logic        id_use_rs, id_use_rt, ex_MemRead, ex_branch_taken, ex_mdu_start;
    logic        mem_req, mem_ack;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic        mdu_done, mem_timeout;
    logic [31:0] perf_stall_cnt;

    pipeline_hazard_ctrl #(
        .MDU_CYCLES  (MDU_C),
        .MEM_TIMEOUT (MEM_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_Rs           (id_Rs),
        .id_Rt           (id_Rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_MemRead      (ex_MemRead),
        .ex_wreg         (ex_wreg),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_start    (ex_mdu_start),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .flush_mem_wb    (flush_mem_wb),
        .mdu_done        (mdu_done),
        .mem_timeout     (mem_timeout),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: an MDU op in EX needs MDU_C elapsed cycles, plus one recovery cycle after any memory wait.
    bit          m_busy;
    int unsigned m_elapsed;
    bit          m_prev_hold;
    bit          m_kill;
    int unsigned m_wait;
    bit          m_to;
    logic [31:0] m_perf;

    task automatic model_reset();
        m_busy = 0; m_elapsed = 0; m_prev_hold = 0; m_kill = 0;
        m_wait = 0; m_to = 0; m_perf = '0;
    endtask

    task automatic idle();
        id_Rs = '0; id_Rt = '0; id_use_rs = 0; id_use_rt = 0;
        ex_MemRead = 0; ex_wreg = '0; ex_branch_taken = 0; ex_mdu_start = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    task automatic tick();
        bit hold, lu, exh, done, accept, spc, fif;
        #1;
        if (rst) begin
            model_reset();
            chk("rst_stall_pc", stall_pc, 0);       chk("rst_stall_if_id", stall_if_id, 0);
            chk("rst_stall_id_ex", stall_id_ex, 0); chk("rst_stall_ex_mem", stall_ex_mem, 0);
            chk("rst_flush_if_id", flush_if_id, 0); chk("rst_flush_id_ex", flush_id_ex, 0);
            chk("rst_flush_ex_mem", flush_ex_mem, 0); chk("rst_flush_mem_wb", flush_mem_wb, 0);
            chk("rst_mdu_done", mdu_done, 0);       chk("rst_mem_timeout", mem_timeout, 0);
            chk("rst_perf", perf_stall_cnt, 0);
            return;
        end
        hold = mem_req && !mem_ack;
        lu = ex_MemRead && ex_wreg != 0 &&
             ((id_use_rs && ex_wreg == id_Rs) || (id_use_rt && ex_wreg == id_Rt));
        accept = 0; done = 0;
        if (m_busy) begin
            exh  = (m_elapsed < MDU_C) || m_prev_hold;
            done = (m_elapsed >= MDU_C) && !m_prev_hold && !hold;
        end else begin
            accept = ex_mdu_start && !hold && !m_prev_hold;
            exh = accept;
        end
        spc = hold || exh || lu;
        fif = (ex_branch_taken || m_kill) && !spc;

        chk("stall_pc", stall_pc, spc);
        chk("stall_if_id", stall_if_id, spc);
        chk("stall_id_ex", stall_id_ex, hold || exh);
        chk("stall_ex_mem", stall_ex_mem, hold);
        chk("flush_mem_wb", flush_mem_wb, hold);
        chk("flush_ex_mem", flush_ex_mem, exh && !hold);
        chk("flush_id_ex", flush_id_ex, lu && !hold && !exh);
        chk("flush_if_id", flush_if_id, fif);
        chk("mdu_done", mdu_done, done);
        chk("mem_timeout", mem_timeout, m_to);
        chk("perf_stall_cnt", perf_stall_cnt, m_perf);

        if (m_busy) begin
            if (done) m_busy = 0;
            else m_elapsed++;
        end else if (accept) begin
            m_busy = 1; m_elapsed = 1;
        end
        m_prev_hold = hold;
        if (fif) m_kill = 0;
        else if (ex_branch_taken && lu && !hold && !exh) m_kill = 1;
        m_wait = hold ? m_wait + 1 : 0;
        if (hold && m_wait >= MEM_TO) m_to = 1;
        m_perf = m_perf + 32'(spc);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2 tick();
        @(negedge clk); rst = 1'b0; tick();

        // Load-use on Rs, then clear
        @(negedge clk); idle(); ex_MemRead = 1; ex_wreg = 5; id_Rs = 5; id_use_rs = 1; tick();
        chk("lu_flush_id_ex", flush_id_ex, 1);
        @(negedge clk); idle(); tick();
        // $zero destination never creates a hazard
        @(negedge clk); ex_MemRead = 1; ex_wreg = 0; id_Rs = 0; id_use_rs = 1; tick();
        chk("zero_reg_stall", stall_pc, 0);

        // MDU op: MDU_C hold cycles, done pulse on the next
        @(negedge clk); idle(); ex_mdu_start = 1;
        repeat (MDU_C) begin tick(); chk("mdu_hold", stall_id_ex, 1); @(negedge clk); end
        tick(); chk("mdu_done_pulse", mdu_done, 1);
        @(negedge clk); idle(); tick();

        // Memory wait of three cycles, timeout sticky afterwards
        @(negedge clk); idle(); mem_req = 1;
        repeat (3) begin tick(); @(negedge clk); end
        mem_ack = 1; tick();
        @(negedge clk); idle(); tick();
        chk("timeout_sticky", mem_timeout, 1);

        // Branch taken with load-use: kill deferred one cycle
        @(negedge clk); idle(); ex_branch_taken = 1; ex_MemRead = 1; ex_wreg = 3;
        id_Rt = 3; id_use_rt = 1; tick();
        @(negedge clk); idle(); tick();
        chk("deferred_kill", flush_if_id, 1);
        @(negedge clk); tick();

        // Asynchronous reset in the middle of an MDU op
        @(negedge clk); idle(); ex_mdu_start = 1; tick();
        @(negedge clk); tick();
        @(negedge clk); #2 rst = 1'b1; tick();
        @(negedge clk); rst = 1'b0; tick();
        @(negedge clk); idle(); tick();

        repeat (3000) begin
            @(negedge clk);
            rst             = ($urandom_range(0, 299) == 0);
            id_Rs           = 5'($urandom_range(0, 7));
            id_Rt           = 5'($urandom_range(0, 7));
            id_use_rs       = ($urandom_range(0, 1) == 1);
            id_use_rt       = ($urandom_range(0, 1) == 1);
            ex_MemRead      = ($urandom_range(0, 9) < 3);
            ex_wreg         = 5'($urandom_range(0, 7));
            ex_branch_taken = ($urandom_range(0, 9) < 2);
            ex_mdu_start    = ($urandom_range(0, 9) < 3);
            mem_req         = ($urandom_range(0, 9) < 3);
            mem_ack         = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
